// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the fetch stage: next-PC select, fault causes, FSM states.
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        PCSRC_PLUS4   = 2'b00,
        PCSRC_TARGET  = 2'b01,
        PCSRC_JALR    = 2'b10,
        PCSRC_ILLEGAL = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_MISALIGN = 2'b01,
        FC_RANGE    = 2'b10,
        FC_ILLEGAL  = 2'b11
    } fault_cause_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FAULT = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage control/status bundle; master drives next-PC controls, slave is the fetch unit.
interface pc_fetch_unit_if;
    logic [1:0]  PCSrc;
    logic [31:0] PCTarget;
    logic [31:0] ALUResult;
    logic        Stall;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        FetchValid;
    logic        Fault;
    logic [1:0]  FaultCause;
    logic [31:0] FaultPC;
    logic [31:0] InstrCount;

    modport master (
        output PCSrc, PCTarget, ALUResult, Stall,
        input  PC, PCPlus4, FetchValid, Fault, FaultCause, FaultPC, InstrCount
    );

    modport slave (
        input  PCSrc, PCTarget, ALUResult, Stall,
        output PC, PCPlus4, FetchValid, Fault, FaultCause, FaultPC, InstrCount
    );
endinterface

// File: rtl/pc_fetch_unit_pc_next_sel.sv
// Combinational next-PC selection and control-flow target legality check.
module pc_next_sel
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 64
) (
    input  logic [31:0] PC,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] PCTarget,
    input  logic [31:0] ALUResult,
    output logic [31:0] candidate,
    output logic        fault,
    output logic [1:0]  cause
);

    logic [32:0] seq_sum;
    logic        seq_wrap;

    // The carry out of PC+4 marks a wrap past the top of the address space.
    assign seq_sum = {1'b0, PC} + 33'd4;

    always_comb begin
        candidate = PC;
        seq_wrap  = 1'b0;
        unique case (PCSrc)
            PCSRC_PLUS4: begin
                candidate = seq_sum[31:0];
                seq_wrap  = seq_sum[32];
            end
            PCSRC_TARGET: candidate = PCTarget;
            PCSRC_JALR:   candidate = ALUResult & 32'hFFFF_FFFE;
            default:      candidate = PC;
        endcase
    end

    always_comb begin
        cause = FC_NONE;
        if (PCSrc == PCSRC_ILLEGAL)
            cause = FC_ILLEGAL;
        else if (candidate[1:0] != 2'b00)
            cause = FC_MISALIGN;
        else if (seq_wrap || ({2'b00, candidate[31:2]} >= IMEM_WORDS))
            cause = FC_RANGE;
    end

    assign fault = (cause != FC_NONE);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch control: boot window, stall, sticky control-flow fault, retire count.
module pc_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS  = 64,
    parameter int unsigned BOOT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    pc_fetch_unit_if.slave  fb
);

    localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

    fetch_state_e state;
    logic [3:0]   boot_cnt;
    logic [31:0]  pc_q;
    logic         fault_q;
    logic [1:0]   fault_cause_q;
    logic [31:0]  fault_pc_q;
    logic [31:0]  instr_count_q;

    logic [31:0]  cand;
    logic         cand_fault;
    logic [1:0]   cand_cause;

    pc_next_sel #(
        .IMEM_WORDS (IMEM_WORDS)
    ) u_next_sel (
        .PC        (pc_q),
        .PCSrc     (fb.PCSrc),
        .PCTarget  (fb.PCTarget),
        .ALUResult (fb.ALUResult),
        .candidate (cand),
        .fault     (cand_fault),
        .cause     (cand_cause)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_BOOT;
            boot_cnt      <= '0;
            pc_q          <= RESET_PC;
            fault_q       <= 1'b0;
            fault_cause_q <= FC_NONE;
            fault_pc_q    <= '0;
            instr_count_q <= '0;
        end else begin
            unique case (state)
                ST_BOOT: begin
                    if (boot_cnt == BOOT_LAST)
                        state <= ST_RUN;
                    else
                        boot_cnt <= boot_cnt + 4'd1;
                end
                ST_RUN: begin
                    // A stalled cycle never classifies; the fault is seen once Stall drops.
                    if (!fb.Stall) begin
                        if (cand_fault) begin
                            fault_q       <= 1'b1;
                            fault_cause_q <= cand_cause;
                            fault_pc_q    <= pc_q;
                            state         <= ST_FAULT;
                        end else begin
                            pc_q          <= cand;
                            instr_count_q <= instr_count_q + 32'd1;
                        end
                    end
                end
                ST_FAULT: ;
                default: state <= ST_FAULT;
            endcase
        end
    end

    assign fb.PC         = pc_q;
    assign fb.PCPlus4    = pc_q + 32'd4;
    assign fb.FetchValid = (state == ST_RUN) && !fb.Stall;
    assign fb.Fault      = fault_q;
    assign fb.FaultCause = fault_cause_q;
    assign fb.FaultPC    = fault_pc_q;
    assign fb.InstrCount = instr_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed table, corner sequences, randomized model compare.
module tb_pc_fetch_unit;

    localparam int unsigned IMEM_WORDS  = 64;
    localparam int unsigned BOOT_CYCLES = 2;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pc_fetch_unit_if bus ();

    pc_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .IMEM_WORDS  (IMEM_WORDS),
        .BOOT_CYCLES (BOOT_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fb    (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Reference model: boot countdown, faulted flag, and 64-bit target arithmetic.
    int          m_boot_left;
    bit          m_faulted;
    logic [31:0] m_pc, m_cnt, m_fpc;
    logic [1:0]  m_cause;

    function automatic void m_reset();
        m_boot_left = BOOT_CYCLES;
        m_faulted   = 1'b0;
        m_pc        = RESET_PC;
        m_cnt       = '0;
        m_fpc       = '0;
        m_cause     = 2'd0;
    endfunction

    function automatic void model_edge();
        longint unsigned t;
        logic [1:0] c;
        if (m_faulted) return;
        if (m_boot_left > 0) begin
            m_boot_left--;
            return;
        end
        if (bus.Stall) return;
        case (bus.PCSrc)
            2'd0:    t = longint'(m_pc) + 4;
            2'd1:    t = longint'(bus.PCTarget);
            2'd2:    t = longint'(bus.ALUResult) & ~64'd1;
            default: t = 0;
        endcase
        if (bus.PCSrc == 2'd3)         c = 2'd3;
        else if (t % 4 != 0)           c = 2'd1;
        else if (t / 4 >= IMEM_WORDS)  c = 2'd2;
        else                           c = 2'd0;
        if (c != 2'd0) begin
            m_faulted = 1'b1;
            m_cause   = c;
            m_fpc     = m_pc;
        end else begin
            m_pc  = t[31:0];
            m_cnt = m_cnt + 32'd1;
        end
    endfunction

    task automatic check_model(input string tag);
        logic fv;
        fv = !m_faulted && (m_boot_left == 0) && !bus.Stall;
        chk({tag, ".PC"},         bus.PC,                m_pc);
        chk({tag, ".PCPlus4"},    bus.PCPlus4,           m_pc + 32'd4);
        chk({tag, ".FetchValid"}, 32'(bus.FetchValid),   32'(fv));
        chk({tag, ".Fault"},      32'(bus.Fault),        32'(m_faulted));
        chk({tag, ".FaultCause"}, 32'(bus.FaultCause),   32'(m_cause));
        chk({tag, ".FaultPC"},    bus.FaultPC,           m_fpc);
        chk({tag, ".InstrCount"}, bus.InstrCount,        m_cnt);
    endtask

    task automatic drive(input logic [1:0] src, input logic [31:0] tgt,
                         input logic [31:0] alu, input logic stall);
        bus.PCSrc     = src;
        bus.PCTarget  = tgt;
        bus.ALUResult = alu;
        bus.Stall     = stall;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(2'd0, 32'd0, 32'd0, 1'b0);
        rst_n = 1'b0;
        m_reset();
        #1;
        check_model("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic boot();
        for (int i = 0; i < int'(BOOT_CYCLES); i++) tick();
    endtask

    task automatic goto_pc(input logic [31:0] a);
        drive(2'd1, a, 32'd0, 1'b0);
        tick();
        chk("goto.PC", bus.PC, a);
    endtask

    typedef struct {
        logic [1:0]  src;
        logic [31:0] tgt;
        logic [31:0] alu;
        logic        stall;
        logic [31:0] e_pc;
        logic        e_fault;
        logic [1:0]  e_cause;
        logic [31:0] e_fpc;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vt[$];

    initial begin
        vt.push_back('{2'd0, 32'h00, 32'h00, 1'b0, 32'h04, 1'b0, 2'd0, 32'h00, 32'd1});
        vt.push_back('{2'd0, 32'h00, 32'h00, 1'b0, 32'h08, 1'b0, 2'd0, 32'h00, 32'd2});
        vt.push_back('{2'd0, 32'h00, 32'h00, 1'b0, 32'h0C, 1'b0, 2'd0, 32'h00, 32'd3});
        vt.push_back('{2'd1, 32'h00, 32'h00, 1'b0, 32'h00, 1'b0, 2'd0, 32'h00, 32'd4});
        vt.push_back('{2'd2, 32'h00, 32'h21, 1'b0, 32'h20, 1'b0, 2'd0, 32'h00, 32'd5});
        vt.push_back('{2'd1, 32'h08, 32'h00, 1'b1, 32'h20, 1'b0, 2'd0, 32'h00, 32'd5});
        vt.push_back('{2'd1, 32'h10, 32'h00, 1'b0, 32'h10, 1'b0, 2'd0, 32'h00, 32'd6});
        vt.push_back('{2'd1, 32'h12, 32'h00, 1'b0, 32'h10, 1'b1, 2'd1, 32'h10, 32'd6});
        vt.push_back('{2'd0, 32'h00, 32'h00, 1'b0, 32'h10, 1'b1, 2'd1, 32'h10, 32'd6});

        // Reset and boot window
        do_reset();
        chk("boot0.FetchValid", 32'(bus.FetchValid), 32'd0);
        tick();
        chk("boot1.FetchValid", 32'(bus.FetchValid), 32'd0);
        tick();
        chk("boot2.FetchValid", 32'(bus.FetchValid), 32'd1);
        chk("boot2.PC", bus.PC, 32'h0);

        foreach (vt[i]) begin
            drive(vt[i].src, vt[i].tgt, vt[i].alu, vt[i].stall);
            tick();
            chk($sformatf("vec%0d.PC", i),         bus.PC,                 vt[i].e_pc);
            chk($sformatf("vec%0d.Fault", i),      32'(bus.Fault),         32'(vt[i].e_fault));
            chk($sformatf("vec%0d.FaultCause", i), 32'(bus.FaultCause),    32'(vt[i].e_cause));
            chk($sformatf("vec%0d.FaultPC", i),    bus.FaultPC,            vt[i].e_fpc);
            chk($sformatf("vec%0d.InstrCount", i), bus.InstrCount,         vt[i].e_cnt);
            check_model($sformatf("vec%0d", i));
        end
        chk("fault.FetchValid", 32'(bus.FetchValid), 32'd0);

        for (int i = 0; i < 10; i++) begin
            drive(2'($urandom), $urandom, $urandom, 1'($urandom));
            tick();
            chk("frozen.PC", bus.PC, 32'h10);
            chk("frozen.Cause", 32'(bus.FaultCause), 32'd1);
        end

        // Sequential step off the end of memory
        do_reset();
        boot();
        goto_pc(32'hFC);
        drive(2'd0, 32'd0, 32'd0, 1'b0);
        tick();
        chk("range.Cause", 32'(bus.FaultCause), 32'd2);
        chk("range.FaultPC", bus.FaultPC, 32'hFC);
        chk("range.PC", bus.PC, 32'hFC);
        check_model("range");

        // Illegal select outranks misalignment
        do_reset();
        boot();
        drive(2'd3, 32'h13, 32'd0, 1'b0);
        tick();
        chk("illegal.Cause", 32'(bus.FaultCause), 32'd3);
        chk("illegal.FaultPC", bus.FaultPC, 32'h0);
        check_model("illegal");

        // Stall masks a pending fault until released
        do_reset();
        boot();
        goto_pc(32'h08);
        drive(2'd3, 32'd0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.PC", bus.PC, 32'h08);
            chk("stall.InstrCount", bus.InstrCount, 32'd1);
            chk("stall.Fault", 32'(bus.Fault), 32'd0);
        end
        bus.Stall = 1'b0;
        tick();
        chk("unstall.Cause", 32'(bus.FaultCause), 32'd3);
        chk("unstall.FaultPC", bus.FaultPC, 32'h08);
        check_model("unstall");

        // Asynchronous reset mid-RUN, stall during the reboot, then reset from FAULT
        do_reset();
        boot();
        goto_pc(32'h40);
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("arst.PC", bus.PC, RESET_PC);
        chk("arst.PCPlus4", bus.PCPlus4, RESET_PC + 32'd4);
        chk("arst.InstrCount", bus.InstrCount, 32'd0);
        chk("arst.FetchValid", 32'(bus.FetchValid), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(2'd3, 32'd0, 32'd0, 1'b1);
        tick();
        tick();
        bus.Stall = 1'b0;
        #1;
        chk("reboot.FetchValid", 32'(bus.FetchValid), 32'd1);
        tick();
        chk("reboot.Fault", 32'(bus.Fault), 32'd1);
        check_model("reboot");
        rst_n = 1'b0;
        m_reset();
        #1;
        chk("frst.Fault", 32'(bus.Fault), 32'd0);
        chk("frst.FaultPC", bus.FaultPC, 32'd0);
        check_model("frst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [1:0] src;
            logic [31:0] tgt, alu;
            r = int'($urandom_range(0, 99));
            if (r < 3 || (m_faulted && $urandom_range(0, 3) == 0)) begin
                do_reset();
                continue;
            end
            r = int'($urandom_range(0, 99));
            src = (r < 50) ? 2'd0 : (r < 75) ? 2'd1 : (r < 93) ? 2'd2 : 2'd3;
            tgt = ($urandom_range(0, 9) == 0) ? $urandom
                                              : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            alu = ($urandom_range(0, 9) == 0) ? $urandom
                                              : {24'd0, 6'($urandom_range(0, 63)), 1'b0, 1'($urandom)};
            drive(src, tgt, alu, ($urandom_range(0, 4) == 0));
            #1;
            check_model("rnd.pre");
            tick();
            check_model("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
